game_flow_fsm: RTL and testbench

Parametrised top-level game-flow controller for the racer: title screen, N-car selection, control-scheme selection, race with lap counting, timeout/cheat banners and a finish screen. Sits between the keyboard/button front end and the renderers, and drives screen-visibility flags, arrow position, selected car, and the gated 4-bit `controls` bus to the car physics. Cursor moves and confirms act on rising edges, so one press is one step. Laps are counted to a configurable race length.

---
 rtl/game_flow_pkg.sv | 51 +++++
 rtl/game_flow_fsm_menu_input_edge.sv | 21 ++
 rtl/game_flow_fsm.sv | 277 +++++++++++++++++++++++++++
 tb/tb_game_flow_fsm.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_pkg.sv
// Shared types and constants for the racer game-flow controller.
// GAME_FLOW_PAUSE_EN adds the PAUSE state.
package game_flow_pkg;

    typedef enum logic [3:0] {
        ST_TITLE,
        ST_SETTLE,
        ST_CAR_SEL,
        ST_CTRL_SEL,
        ST_GAME,
        ST_SLOW,
        ST_CHEAT,
        ST_FINISH
`ifdef GAME_FLOW_PAUSE_EN
        , ST_PAUSE
`endif
    } state_e;

    // one-hot decoded keyboard bits
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;

    // board buttons {R,L,D,U}
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;

    // request slots in the edge detector
    localparam int REQ_CONFIRM = 0;
    localparam int REQ_LEFT    = 1;
    localparam int REQ_RIGHT   = 2;
    localparam int REQ_PAUSE   = 3;

    localparam logic CTRL_KEYBOARD = 1'b0;
    localparam logic CTRL_BUTTONS  = 1'b1;

    // ceil(log2(n)), never below 1 so a select port always has a bit
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_flow_fsm_menu_input_edge.sv
// Registers the combined menu/pause request levels and emits one-cycle rise pulses.
// The history register clears on reset, so a level held through reset release counts as a rise.
module menu_input_edge #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= '0;
        else         prev_q <= req_i;
    end

    assign rise_o = req_i & ~prev_q;

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level racer game-flow controller: menus, race lap counting, banners and finish screen.
// Optional pause state compiled in with GAME_FLOW_PAUSE_EN.
module game_flow_fsm
    import game_flow_pkg::*;
#(
    parameter int unsigned NUM_CARS     = 2,
    parameter int unsigned NUM_LAPS     = 3,
    parameter int unsigned DELAY        = 10_000_000,
    parameter int unsigned TEXT_TIME    = 130_000_000,
    parameter int unsigned ARROW_X0     = 256,
    parameter int unsigned ARROW_DX     = 416,
    parameter int unsigned ARROW_Y_CAR  = 470,
    parameter int unsigned ARROW_Y_CTRL = 500,
    parameter logic [7:0]  PAUSE_CODE   = 8'h76
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic [3:0]                    btn,
    input  logic [5:0]                    key,
    input  logic [7:0]                    keycode,
    input  logic                          lap_finished,
    input  logic                          checkpoints_passed,
    input  logic                          max_lap_time_exceeded,
    output logic                          title_screen_visible,
    output logic                          car_select_visible,
    output logic                          control_select_visible,
    output logic                          game_visible,
    output logic                          finish_visible,
    output logic                          arrow_visible,
    output logic [10:0]                   arrow_xpos,
    output logic [10:0]                   arrow_ypos,
    output logic                          too_slow_visible,
    output logic                          cheater_visible,
    output logic                          paused,
    output logic [clog2(NUM_CARS)-1:0]    car_sel,
    output logic                          ctrl_sel,
    output logic [3:0]                    lap_count,
    output logic [3:0]                    controls
);

    localparam int CW = clog2(NUM_CARS);
    localparam logic [CW-1:0] CAR_MAX = CW'(NUM_CARS - 1);

`ifdef GAME_FLOW_PAUSE_EN
    localparam int NREQ = 4;
`else
    localparam int NREQ = 3;
`endif

    // ---------------------------------------------------------------- edges
    logic [NREQ-1:0] req, rise;
    logic            confirm, left, right;

    assign req[REQ_CONFIRM] = btn[BTN_U] | key[KEY_ENTER];
    assign req[REQ_LEFT]    = btn[BTN_L] | key[KEY_LEFT];
    assign req[REQ_RIGHT]   = btn[BTN_R] | key[KEY_RIGHT];
`ifdef GAME_FLOW_PAUSE_EN
    assign req[REQ_PAUSE]   = (keycode == PAUSE_CODE);
`else
    logic unused_pause;
    assign unused_pause = (keycode == PAUSE_CODE);
`endif

    logic unused_key;
    assign unused_key = key[5];

    menu_input_edge #(.N(NREQ)) u_edge (
        .clk_i  (pclk),
        .rst_ni (rst_n),
        .req_i  (req),
        .rise_o (rise)
    );

    assign confirm = rise[REQ_CONFIRM];
    assign left    = rise[REQ_LEFT];
    assign right   = rise[REQ_RIGHT];

    // ---------------------------------------------------------------- state
    state_e          state_q, state_d, target_q, target_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [CW-1:0]   cursor_q, cursor_d, car_q, car_d, cur_max;
    logic            ctrl_q, ctrl_d;
    logic [3:0]      lap_q, lap_d, lap_inc;
    logic            valid_lap, lap_done;

    assign lap_inc   = lap_q + 4'd1;
    assign lap_done  = (lap_inc == 4'(NUM_LAPS));
    assign valid_lap = lap_finished & checkpoints_passed;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        car_d    = car_q;
        ctrl_d   = ctrl_q;
        lap_d    = lap_q;
        cur_max  = (state_q == ST_CAR_SEL) ? CAR_MAX : CW'(1);

        case (state_q)
            ST_TITLE: begin
                if ((|btn) || (keycode != 8'h00)) begin
                    state_d  = ST_SETTLE;
                    target_d = ST_CAR_SEL;
                    cnt_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == DELAY) begin
                    state_d  = target_q;
                    cnt_d    = '0;
                    cursor_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_CAR_SEL, ST_CTRL_SEL: begin
                // confirm wins over a move in the same cycle
                if (confirm) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    if (state_q == ST_CAR_SEL) begin
                        car_d    = cursor_q;
                        target_d = ST_CTRL_SEL;
                    end else begin
                        ctrl_d   = cursor_q[0];
                        lap_d    = '0;
                        target_d = ST_GAME;
                    end
                end else if (right && !left) begin
                    if (cursor_q != cur_max) cursor_d = cursor_q + CW'(1);
                end else if (left && !right) begin
                    if (cursor_q != '0) cursor_d = cursor_q - CW'(1);
                end
            end
            ST_GAME: begin
                if (max_lap_time_exceeded) begin
                    state_d = ST_SLOW;
                    cnt_d   = '0;
                end else if (lap_finished && !checkpoints_passed) begin
                    state_d = ST_CHEAT;
                    cnt_d   = '0;
                end else if (valid_lap) begin
                    lap_d = lap_inc;
                    if (lap_done) begin
                        state_d = ST_FINISH;
                        cnt_d   = '0;
                    end
`ifdef GAME_FLOW_PAUSE_EN
                end else if (rise[REQ_PAUSE]) begin
                    state_d = ST_PAUSE;
`endif
                end
            end
            ST_SLOW, ST_CHEAT: begin
                // banner keeps counting laps but ignores new timeout/cheat events
                if (valid_lap) lap_d = lap_inc;
                if (valid_lap && lap_done) begin
                    state_d = ST_FINISH;
                    cnt_d   = '0;
                end else if (cnt_q == TEXT_TIME - 1) begin
                    state_d = ST_GAME;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FINISH: begin
                if (cnt_q != TEXT_TIME) begin
                    cnt_d = cnt_q + 32'd1;
                end else if (confirm) begin
                    state_d = ST_TITLE;
                    cnt_d   = '0;
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSE: begin
                if (rise[REQ_PAUSE]) state_d = ST_GAME;
            end
`endif
            default: state_d = ST_TITLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    logic        title_d, car_vis_d, ctrl_vis_d, game_d, finish_d, arrow_d;
    logic        slow_d, cheat_d, paused_d, in_play;
    logic [10:0] xpos_d, ypos_d;
    logic [3:0]  controls_d;
    logic        title_q, car_vis_q, ctrl_vis_q, game_q, finish_q, arrow_q;
    logic        slow_q, cheat_q, paused_q;
    logic [10:0] xpos_q, ypos_q;
    logic [3:0]  controls_q;

    always_comb begin
        title_d    = (state_q == ST_TITLE);
        car_vis_d  = (state_q == ST_CAR_SEL);
        ctrl_vis_d = (state_q == ST_CTRL_SEL);
        finish_d   = (state_q == ST_FINISH);
        slow_d     = (state_q == ST_SLOW);
        cheat_d    = (state_q == ST_CHEAT);
        in_play    = (state_q == ST_GAME) || slow_d || cheat_d;
`ifdef GAME_FLOW_PAUSE_EN
        paused_d   = (state_q == ST_PAUSE);
`else
        paused_d   = 1'b0;
`endif
        game_d     = in_play || paused_d;
        arrow_d    = car_vis_d || ctrl_vis_d;
        xpos_d     = arrow_d ? 11'(ARROW_X0 + 32'(cursor_q) * ARROW_DX) : 11'd0;
        ypos_d     = car_vis_d  ? 11'(ARROW_Y_CAR)  :
                     ctrl_vis_d ? 11'(ARROW_Y_CTRL) : 11'd0;
        controls_d = '0;
        if (in_play) controls_d = (ctrl_q == CTRL_BUTTONS) ? btn : key[3:0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TITLE;
            target_q   <= ST_TITLE;
            cnt_q      <= '0;
            cursor_q   <= '0;
            car_q      <= '0;
            ctrl_q     <= CTRL_KEYBOARD;
            lap_q      <= '0;
            title_q    <= 1'b0;
            car_vis_q  <= 1'b0;
            ctrl_vis_q <= 1'b0;
            game_q     <= 1'b0;
            finish_q   <= 1'b0;
            arrow_q    <= 1'b0;
            slow_q     <= 1'b0;
            cheat_q    <= 1'b0;
            paused_q   <= 1'b0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            controls_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            cursor_q   <= cursor_d;
            car_q      <= car_d;
            ctrl_q     <= ctrl_d;
            lap_q      <= lap_d;
            title_q    <= title_d;
            car_vis_q  <= car_vis_d;
            ctrl_vis_q <= ctrl_vis_d;
            game_q     <= game_d;
            finish_q   <= finish_d;
            arrow_q    <= arrow_d;
            slow_q     <= slow_d;
            cheat_q    <= cheat_d;
            paused_q   <= paused_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            controls_q <= controls_d;
        end
    end

    assign title_screen_visible   = title_q;
    assign car_select_visible     = car_vis_q;
    assign control_select_visible = ctrl_vis_q;
    assign game_visible           = game_q;
    assign finish_visible         = finish_q;
    assign arrow_visible          = arrow_q;
    assign arrow_xpos             = xpos_q;
    assign arrow_ypos             = ypos_q;
    assign too_slow_visible       = slow_q;
    assign cheater_visible        = cheat_q;
    assign paused                 = paused_q;
    assign car_sel                = car_q;
    assign ctrl_sel               = ctrl_q;
    assign lap_count              = lap_q;
    assign controls               = controls_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with DELAY=4, TEXT_TIME=8, NUM_CARS=3, NUM_LAPS=2.
module tb_game_flow_fsm;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = '0;
    logic [5:0]  key = '0;
    logic [7:0]  keycode = '0;
    logic        lap_finished = 1'b0, checkpoints_passed = 1'b0, max_lap_time_exceeded = 1'b0;
    logic        title_screen_visible, car_select_visible, control_select_visible;
    logic        game_visible, finish_visible, arrow_visible;
    logic [10:0] arrow_xpos, arrow_ypos;
    logic        too_slow_visible, cheater_visible, paused;
    logic [1:0]  car_sel;
    logic        ctrl_sel;
    logic [3:0]  lap_count, controls;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 pclk = ~pclk;

    game_flow_fsm #(
        .NUM_CARS(3), .NUM_LAPS(2), .DELAY(4), .TEXT_TIME(8)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .btn(btn), .key(key), .keycode(keycode),
        .lap_finished(lap_finished), .checkpoints_passed(checkpoints_passed),
        .max_lap_time_exceeded(max_lap_time_exceeded),
        .title_screen_visible(title_screen_visible), .car_select_visible(car_select_visible),
        .control_select_visible(control_select_visible), .game_visible(game_visible),
        .finish_visible(finish_visible), .arrow_visible(arrow_visible),
        .arrow_xpos(arrow_xpos), .arrow_ypos(arrow_ypos),
        .too_slow_visible(too_slow_visible), .cheater_visible(cheater_visible),
        .paused(paused), .car_sel(car_sel), .ctrl_sel(ctrl_sel),
        .lap_count(lap_count), .controls(controls)
    );

    logic [52:0] all_outs;
    assign all_outs = {title_screen_visible, car_select_visible, control_select_visible,
                       game_visible, finish_visible, arrow_visible, arrow_xpos, arrow_ypos,
                       too_slow_visible, cheater_visible, paused, car_sel, ctrl_sel,
                       lap_count, controls};

    task automatic step(input int k);
        repeat (k) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic press_btn(input int b);
        btn[b] = 1'b1;
        step(1);
        btn[b] = 1'b0;
        step(1);
    endtask

    task automatic valid_lap();
        lap_finished = 1'b1;
        checkpoints_passed = 1'b1;
        step(1);
        lap_finished = 1'b0;
        checkpoints_passed = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        step(3);
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL reset_outputs: got %0h expected 0", all_outs);
        end
        rst_n = 1'b1;
        step(1);
        tests++;
        if (title_screen_visible !== 1'b1) begin
            fails++; $display("FAIL title_after_release: got %b expected 1", title_screen_visible);
        end
    endtask

    task automatic test_title_to_car();
        keycode = 8'h1C;
        step(1);
        keycode = 8'h00;
        step(1);
        tests++;
        if (title_screen_visible !== 1'b0) begin
            fails++; $display("FAIL title_leave: got %b expected 0", title_screen_visible);
        end
        n = 0;
        while (!car_select_visible && n < 40) begin step(1); n++; end
        tests++;
        if (n != 5) begin
            fails++; $display("FAIL settle_length: got %0d cycles expected 5", n);
        end
        tests++;
        if (arrow_xpos !== 11'd256 || arrow_ypos !== 11'd470 || arrow_visible !== 1'b1) begin
            fails++; $display("FAIL car_arrow_init: got x=%0d y=%0d v=%b expected x=256 y=470 v=1",
                              arrow_xpos, arrow_ypos, arrow_visible);
        end
    endtask

    task automatic test_car_select();
        btn[3] = 1'b1;
        step(20);
        btn[3] = 1'b0;
        step(2);
        tests++;
        if (arrow_xpos !== 11'd672) begin
            fails++; $display("FAIL right_held: got %0d expected 672", arrow_xpos);
        end
        repeat (3) press_btn(3);
        step(1);
        tests++;
        if (arrow_xpos !== 11'd1088) begin
            fails++; $display("FAIL right_saturate: got %0d expected 1088", arrow_xpos);
        end
        press_btn(2);
        press_btn(2);
        press_btn(2);
        step(1);
        tests++;
        if (arrow_xpos !== 11'd256) begin
            fails++; $display("FAIL left_saturate: got %0d expected 256", arrow_xpos);
        end
        press_btn(3);
        press_btn(3);
        press_btn(0);
        tests++;
        if (car_sel !== 2'd2 || car_select_visible !== 1'b0) begin
            fails++; $display("FAIL car_confirm: got car_sel=%0d vis=%b expected 2 0",
                              car_sel, car_select_visible);
        end
    endtask

    task automatic test_ctrl_select();
        n = 0;
        while (!control_select_visible && n < 40) begin step(1); n++; end
        tests++;
        if (control_select_visible !== 1'b1 || arrow_ypos !== 11'd500 || arrow_xpos !== 11'd256) begin
            fails++; $display("FAIL ctrl_screen: got vis=%b x=%0d y=%0d expected 1 256 500",
                              control_select_visible, arrow_xpos, arrow_ypos);
        end
        press_btn(3);
        press_btn(3);
        step(1);
        tests++;
        if (arrow_xpos !== 11'd672) begin
            fails++; $display("FAIL ctrl_saturate: got %0d expected 672", arrow_xpos);
        end
        press_btn(0);
        tests++;
        if (ctrl_sel !== 1'b1 || lap_count !== 4'd0) begin
            fails++; $display("FAIL ctrl_confirm: got ctrl_sel=%b lap=%0d expected 1 0", ctrl_sel, lap_count);
        end
        n = 0;
        while (!game_visible && n < 40) begin step(1); n++; end
    endtask

    task automatic test_controls_game();
        btn = 4'b1010;
        step(1);
        tests++;
        if (controls !== 4'b1010 || game_visible !== 1'b1) begin
            fails++; $display("FAIL controls_btn: got %b game=%b expected 1010 1", controls, game_visible);
        end
        btn = 4'b0000;
        key = 6'b000101;
        step(1);
        tests++;
        if (controls !== 4'b0000) begin
            fails++; $display("FAIL controls_ignores_key: got %b expected 0000", controls);
        end
        key = '0;
        step(1);
    endtask

    task automatic test_cheat();
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        step(1);
        n = 0;
        while (cheater_visible && game_visible && n < 30) begin n++; step(1); end
        tests++;
        if (n != 8) begin
            fails++; $display("FAIL cheat_banner_len: got %0d expected 8", n);
        end
        tests++;
        if (game_visible !== 1'b1 || cheater_visible !== 1'b0 || lap_count !== 4'd0) begin
            fails++; $display("FAIL cheat_return: got game=%b cheat=%b lap=%0d expected 1 0 0",
                              game_visible, cheater_visible, lap_count);
        end
    endtask

    task automatic test_laps_finish();
        valid_lap();
        tests++;
        if (lap_count !== 4'd1 || game_visible !== 1'b1) begin
            fails++; $display("FAIL lap_one: got lap=%0d game=%b expected 1 1", lap_count, game_visible);
        end
        valid_lap();
        tests++;
        if (finish_visible !== 1'b1 || game_visible !== 1'b0 || lap_count !== 4'd2) begin
            fails++; $display("FAIL finish_enter: got fin=%b game=%b lap=%0d expected 1 0 2",
                              finish_visible, game_visible, lap_count);
        end
        step(1);
        btn[0] = 1'b1;
        step(1);
        btn[0] = 1'b0;
        step(1);
        tests++;
        if (finish_visible !== 1'b1 || title_screen_visible !== 1'b0) begin
            fails++; $display("FAIL finish_early_confirm: got fin=%b title=%b expected 1 0",
                              finish_visible, title_screen_visible);
        end
        step(4);
        btn[0] = 1'b1;
        step(1);
        btn[0] = 1'b0;
        step(1);
        tests++;
        if (title_screen_visible !== 1'b1 || finish_visible !== 1'b0) begin
            fails++; $display("FAIL finish_confirm: got title=%b fin=%b expected 1 0",
                              title_screen_visible, finish_visible);
        end
        tests++;
        if (car_sel !== 2'd2 || ctrl_sel !== 1'b1 || lap_count !== 4'd2) begin
            fails++; $display("FAIL finish_keep: got car=%0d ctrl=%b lap=%0d expected 2 1 2",
                              car_sel, ctrl_sel, lap_count);
        end
    endtask

    task automatic test_confirm_beats_move();
        keycode = 8'h1C;
        step(1);
        keycode = 8'h00;
        n = 0;
        while (!car_select_visible && n < 40) begin step(1); n++; end
        btn = 4'b0010;
        step(1);
        tests++;
        if (controls !== 4'b0000) begin
            fails++; $display("FAIL controls_in_menu: got %b expected 0000", controls);
        end
        btn = 4'b1001;
        step(1);
        btn = 4'b0000;
        step(1);
        tests++;
        if (car_sel !== 2'd0 || car_select_visible !== 1'b0) begin
            fails++; $display("FAIL confirm_beats_move: got car=%0d vis=%b expected 0 0",
                              car_sel, car_select_visible);
        end
        n = 0;
        while (!control_select_visible && n < 40) begin step(1); n++; end
        press_btn(0);
        tests++;
        if (ctrl_sel !== 1'b0) begin
            fails++; $display("FAIL ctrl_keyboard: got %b expected 0", ctrl_sel);
        end
        n = 0;
        while (!game_visible && n < 40) begin step(1); n++; end
        key = 6'b000101;
        step(1);
        tests++;
        if (controls !== 4'b0101) begin
            fails++; $display("FAIL controls_key: got %b expected 0101", controls);
        end
        key = '0;
        step(1);
    endtask

    task automatic test_slow_priority();
        max_lap_time_exceeded = 1'b1;
        lap_finished = 1'b1;
        checkpoints_passed = 1'b1;
        step(1);
        max_lap_time_exceeded = 1'b0;
        lap_finished = 1'b0;
        checkpoints_passed = 1'b0;
        step(1);
        tests++;
        if (too_slow_visible !== 1'b1 || cheater_visible !== 1'b0 || lap_count !== 4'd0 ||
            game_visible !== 1'b1) begin
            fails++; $display("FAIL slow_priority: got slow=%b cheat=%b lap=%0d game=%b expected 1 0 0 1",
                              too_slow_visible, cheater_visible, lap_count, game_visible);
        end
        n = 0;
        while (too_slow_visible && n < 30) begin n++; step(1); end
        tests++;
        if (n != 8) begin
            fails++; $display("FAIL slow_banner_len: got %0d expected 8", n);
        end
    endtask

    task automatic test_pause();
`ifdef GAME_FLOW_PAUSE_EN
        keycode = 8'h76;
        step(1);
        keycode = 8'h00;
        step(1);
        key = 6'b000011;
        step(1);
        tests++;
        if (paused !== 1'b1 || game_visible !== 1'b1 || controls !== 4'b0000) begin
            fails++; $display("FAIL pause_enter: got p=%b game=%b ctl=%b expected 1 1 0000",
                              paused, game_visible, controls);
        end
        key = '0;
        valid_lap();
        tests++;
        if (lap_count !== 4'd0) begin
            fails++; $display("FAIL pause_lap_ignored: got %0d expected 0", lap_count);
        end
        keycode = 8'h76;
        step(1);
        keycode = 8'h00;
        step(1);
        tests++;
        if (paused !== 1'b0 || game_visible !== 1'b1) begin
            fails++; $display("FAIL pause_exit: got p=%b game=%b expected 0 1", paused, game_visible);
        end
`else
        keycode = 8'h76;
        step(1);
        keycode = 8'h00;
        step(1);
        tests++;
        if (paused !== 1'b0 || game_visible !== 1'b1) begin
            fails++; $display("FAIL pause_disabled: got p=%b game=%b expected 0 1", paused, game_visible);
        end
`endif
    endtask

    task automatic test_back_to_title();
        valid_lap();
        valid_lap();
        step(10);
        press_btn(0);
        tests++;
        if (title_screen_visible !== 1'b1) begin
            fails++; $display("FAIL run2_title: got %b expected 1", title_screen_visible);
        end
    endtask

    task automatic test_reset_in_settle();
        keycode = 8'h1C;
        step(1);
        keycode = 8'h00;
        n = 0;
        while (!car_select_visible && n < 40) begin step(1); n++; end
        press_btn(3);
        press_btn(0);
        tests++;
        if (car_sel !== 2'd1) begin
            fails++; $display("FAIL pre_reset_car: got %0d expected 1", car_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL async_reset: got %0h expected 0", all_outs);
        end
        step(2);
        rst_n = 1'b1;
        step(6);
        tests++;
        if (title_screen_visible !== 1'b1 || car_select_visible !== 1'b0) begin
            fails++; $display("FAIL reset_target_cleared: got title=%b car=%b expected 1 0",
                              title_screen_visible, car_select_visible);
        end
    endtask

    initial begin
        test_reset();
        test_title_to_car();
        test_car_select();
        test_ctrl_select();
        test_controls_game();
        test_cheat();
        test_laps_finish();
        test_confirm_beats_move();
        test_slow_priority();
        test_pause();
        test_back_to_title();
        test_reset_in_settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
